reg_wb_ctrl: RTL and testbench



---
 rtl/reg_wb_ctrl_pkg.sv | 15 +
 rtl/reg_wb_ctrl_wb_fifo.sv | 54 +++++
 rtl/reg_wb_ctrl.sv | 137 +++++++++++++
 tb/tb_reg_wb_ctrl.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_wb_ctrl_pkg.sv
// Shared definitions for the write-back controller: default widths and write-back source codes.
// The optional combinational bypass port set is enabled by defining WB_BYPASS_EN.
package reg_wb_ctrl_pkg;

   localparam int WB_NUM_REG        = 32;
   localparam int WB_REG_ADDR_WIDTH = 5;
   localparam int WB_REG_WIDTH      = 32;

   typedef enum logic [1:0] {
      WB_SRC_NONE = 2'd0,
      WB_SRC_ALU  = 2'd1,
      WB_SRC_LSU  = 2'd2
   } wb_src_e;

endpackage

// File: rtl/reg_wb_ctrl_wb_fifo.sv
// Small synchronous FIFO holding load results {rd, data} until they win the write port.
// A push while full is dropped even if a pop happens in the same cycle.
module wb_fifo #(
   parameter int WIDTH = 37,
   parameter int DEPTH = 2
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         wdata,
   output logic [WIDTH-1:0]         rdata,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rdata   = mem[rd_ptr];

   // Depth is a power of two, so the pointers wrap by plain overflow.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/reg_wb_ctrl.sv
// Write-back controller: arbitrates ALU results and buffered load results onto one registered
// register-file write port, and tracks pending loads per register. Optional: WB_BYPASS_EN.
module reg_wb_ctrl
   import reg_wb_ctrl_pkg::*;
#(
   parameter int NUM_REG        = WB_NUM_REG,
   parameter int REG_ADDR_WIDTH = WB_REG_ADDR_WIDTH,
   parameter int REG_WIDTH      = WB_REG_WIDTH,
   parameter int FIFO_DEPTH     = 2,
   parameter int STARVE_LIMIT   = 4
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic                      alu_valid,
   output logic                      alu_ready,
   input  logic [REG_ADDR_WIDTH-1:0] alu_rd,
   input  logic [REG_WIDTH-1:0]      alu_data,
   input  logic                      lsu_issue,
   input  logic [REG_ADDR_WIDTH-1:0] lsu_issue_rd,
   input  logic                      lsu_valid,
   output logic                      lsu_ready,
   input  logic [REG_ADDR_WIDTH-1:0] lsu_rd,
   input  logic [REG_WIDTH-1:0]      lsu_data,
   output logic                      wr_en,
   output logic [REG_ADDR_WIDTH-1:0] addr_rd,
   output logic [REG_WIDTH-1:0]      data_rd,
   output logic [NUM_REG-1:0]        busy
`ifdef WB_BYPASS_EN
   ,
   output logic                      byp_valid,
   output logic [REG_ADDR_WIDTH-1:0] byp_rd,
   output logic [REG_WIDTH-1:0]      byp_data
`endif
);

   localparam int ENTRY_W = REG_ADDR_WIDTH + REG_WIDTH;
   localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;
   localparam int STV_W   = $clog2(STARVE_LIMIT + 1);
   localparam logic [STV_W-1:0] STARVE_MAX = STV_W'(STARVE_LIMIT);

   logic                      fifo_push;
   logic                      fifo_pop;
   logic                      fifo_full;
   logic                      fifo_empty;
   logic [CNT_W-1:0]          fifo_count;
   logic [ENTRY_W-1:0]        fifo_rdata;
   logic [REG_ADDR_WIDTH-1:0] head_rd;
   logic [REG_WIDTH-1:0]      head_data;

   logic [STV_W-1:0]          starve_cnt;
   logic                      starve_mode;
   wb_src_e                   sel_src;
   logic                      grant;
   logic [REG_ADDR_WIDTH-1:0] sel_rd;
   logic [REG_WIDTH-1:0]      sel_data;
   logic [NUM_REG-1:0]        busy_next;

   wb_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push    (fifo_push),
      .pop     (fifo_pop),
      .wdata   ({lsu_rd, lsu_data}),
      .rdata   (fifo_rdata),
      .count   (fifo_count),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   assign {head_rd, head_data} = fifo_rdata;
   assign lsu_ready = (fifo_count < CNT_W'(FIFO_DEPTH));
   assign fifo_push = lsu_valid && !fifo_full;
   assign alu_ready = !starve_mode;

   // ALU wins by default; a load that has lost STARVE_LIMIT times in a row is forced through.
   always_comb begin
      starve_mode = (starve_cnt == STARVE_MAX);
      sel_src     = WB_SRC_NONE;
      if (alu_valid && !starve_mode) sel_src = WB_SRC_ALU;
      else if (!fifo_empty)          sel_src = WB_SRC_LSU;
      grant    = (sel_src != WB_SRC_NONE);
      fifo_pop = (sel_src == WB_SRC_LSU);
      sel_rd   = (sel_src == WB_SRC_LSU) ? head_rd   : alu_rd;
      sel_data = (sel_src == WB_SRC_LSU) ? head_data : alu_data;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         starve_cnt <= '0;
      end else if (fifo_empty || fifo_pop) begin
         starve_cnt <= '0;
      end else if (sel_src == WB_SRC_ALU && starve_cnt != STARVE_MAX) begin
         starve_cnt <= starve_cnt + 1'b1;
      end
   end

   // A new issue to the register being retired keeps it busy: the set is applied last.
   always_comb begin
      busy_next = busy;
      if (fifo_pop)  busy_next[head_rd]      = 1'b0;
      if (lsu_issue) busy_next[lsu_issue_rd] = 1'b1;
      busy_next[0] = 1'b0;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         busy <= '0;
      end else begin
         busy <= busy_next;
      end
   end

   // Write stage: one cycle after the grant; x0 targets complete the handshake silently.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_en   <= 1'b0;
         addr_rd <= '0;
         data_rd <= '0;
      end else if (grant) begin
         wr_en   <= (sel_rd != '0);
         addr_rd <= sel_rd;
         data_rd <= sel_data;
      end else begin
         wr_en   <= 1'b0;
      end
   end

`ifdef WB_BYPASS_EN
   assign byp_valid = grant && (sel_rd != '0);
   assign byp_rd    = sel_rd;
   assign byp_data  = sel_data;
`endif

endmodule

// File: tb/tb_reg_wb_ctrl.sv
// Bench for reg_wb_ctrl: queue-based reference model compared every cycle, plus directed
// scenarios with literal expectations.
module tb_reg_wb_ctrl;

   localparam int NR    = 32;
   localparam int AW    = 5;
   localparam int DW    = 32;
   localparam int DEPTH = 2;
   localparam int LIMIT = 4;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          alu_valid = 1'b0;
   logic          alu_ready;
   logic [AW-1:0] alu_rd = '0;
   logic [DW-1:0] alu_data = '0;
   logic          lsu_issue = 1'b0;
   logic [AW-1:0] lsu_issue_rd = '0;
   logic          lsu_valid = 1'b0;
   logic          lsu_ready;
   logic [AW-1:0] lsu_rd = '0;
   logic [DW-1:0] lsu_data = '0;
   logic          wr_en;
   logic [AW-1:0] addr_rd;
   logic [DW-1:0] data_rd;
   logic [NR-1:0] busy;
`ifdef WB_BYPASS_EN
   logic          byp_valid;
   logic [AW-1:0] byp_rd;
   logic [DW-1:0] byp_data;
`endif

   always #5 clk = ~clk;

   reg_wb_ctrl #(
      .NUM_REG(NR), .REG_ADDR_WIDTH(AW), .REG_WIDTH(DW),
      .FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)
   ) dut (
      .clk(clk), .reset_n(reset_n),
      .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
      .lsu_issue(lsu_issue), .lsu_issue_rd(lsu_issue_rd),
      .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
      .wr_en(wr_en), .addr_rd(addr_rd), .data_rd(data_rd), .busy(busy)
`ifdef WB_BYPASS_EN
      , .byp_valid(byp_valid), .byp_rd(byp_rd), .byp_data(byp_data)
`endif
   );

   int n_checks = 0;
   int n_pass   = 0;
   bit chk_on   = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   // Reference model: load buffer as a queue of pending results, counters as plain integers.
   typedef struct {
      logic [AW-1:0] rd;
      logic [DW-1:0] data;
   } ent_t;

   ent_t          mq[$];
   ent_t          m_head;
   ent_t          m_new;
   int            m_starve = 0;
   logic [NR-1:0] m_busy = '0;
   logic          m_wr = 1'b0;
   logic [AW-1:0] m_addr = '0;
   logic [DW-1:0] m_data = '0;
   bit            m_alu_win;
   bit            m_lsu_win;
   bit            m_room;
   bit            m_was_empty;

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mq.delete();
         m_starve = 0;
         m_busy   = '0;
         m_wr     = 1'b0;
         m_addr   = '0;
         m_data   = '0;
      end else begin
         m_was_empty = (mq.size() == 0);
         m_room      = (mq.size() < DEPTH);
         m_alu_win   = alu_valid && (m_starve != LIMIT);
         m_lsu_win   = !m_alu_win && !m_was_empty;
         if (m_lsu_win) m_head = mq.pop_front();
         if (m_alu_win) begin
            m_wr = (alu_rd != 0); m_addr = alu_rd; m_data = alu_data;
         end else if (m_lsu_win) begin
            m_wr = (m_head.rd != 0); m_addr = m_head.rd; m_data = m_head.data;
         end else begin
            m_wr = 1'b0;
         end
         if (m_lsu_win) m_busy[m_head.rd] = 1'b0;
         if (lsu_issue && lsu_issue_rd != 0) m_busy[lsu_issue_rd] = 1'b1;
         if (m_was_empty || m_lsu_win) m_starve = 0;
         else if (m_alu_win && m_starve < LIMIT) m_starve = m_starve + 1;
         if (lsu_valid && m_room) begin
            m_new.rd = lsu_rd; m_new.data = lsu_data;
            mq.push_back(m_new);
         end
      end
   end

   always @(negedge clk) begin
      if (chk_on) begin
         chk("alu_ready", 64'(alu_ready), 64'(m_starve != LIMIT));
         chk("lsu_ready", 64'(lsu_ready), 64'(mq.size() < DEPTH));
         chk("wr_en",     64'(wr_en),     64'(m_wr));
         chk("addr_rd",   64'(addr_rd),   64'(m_addr));
         chk("data_rd",   64'(data_rd),   64'(m_data));
         chk("busy",      64'(busy),      64'(m_busy));
      end
   end

   task automatic cyc();
      @(negedge clk);
      #1;
   endtask

   initial begin
      cyc(); cyc();
      chk_on = 1'b1;
      chk("rst_wr_en", 64'(wr_en), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_lsu_ready", 64'(lsu_ready), 64'd1);
      reset_n = 1'b1;
      cyc();

      // single ALU write then idle
      alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
      cyc();
      chk("alu_wr_en", 64'(wr_en), 64'd1);
      chk("alu_addr", 64'(addr_rd), 64'd5);
      chk("alu_data", 64'(data_rd), 64'hDEADBEEF);
      alu_valid = 1'b0;
      cyc();
      chk("alu_idle_wr_en", 64'(wr_en), 64'd0);

      // ALU write to x0
      alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h1234;
      chk("x0_alu_ready", 64'(alu_ready), 64'd1);
      cyc();
      chk("x0_wr_en", 64'(wr_en), 64'd0);
      alu_valid = 1'b0;

      // issue then return a load to x7
      lsu_issue = 1'b1; lsu_issue_rd = 5'd7;
      cyc();
      chk("busy7_set", 64'(busy[7]), 64'd1);
      lsu_issue = 1'b0;
      lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_data = 32'hA5A5A5A5;
      cyc();
      lsu_valid = 1'b0;
      cyc();
      chk("ld7_wr_en", 64'(wr_en), 64'd1);
      chk("ld7_addr", 64'(addr_rd), 64'd7);
      chk("ld7_data", 64'(data_rd), 64'hA5A5A5A5);
      chk("busy7_clr", 64'(busy[7]), 64'd0);

      // anti-starvation with the ALU busy every cycle
      alu_valid = 1'b1; alu_rd = 5'd10; alu_data = 32'h100;
      lsu_valid = 1'b1; lsu_rd = 5'd3; lsu_data = 32'h33;
      cyc();
      lsu_rd = 5'd4; lsu_data = 32'h44;
      cyc();
      chk("full_lsu_ready", 64'(lsu_ready), 64'd0);
      lsu_valid = 1'b0;
      repeat (3) begin
         cyc();
         chk("starve_alu_addr", 64'(addr_rd), 64'd10);
      end
      chk("starve1_alu_ready", 64'(alu_ready), 64'd0);
      cyc();
      chk("forced3_addr", 64'(addr_rd), 64'd3);
      chk("forced3_data", 64'(data_rd), 64'h33);
      chk("after3_alu_ready", 64'(alu_ready), 64'd1);
      repeat (4) cyc();
      chk("starve2_alu_ready", 64'(alu_ready), 64'd0);
      cyc();
      chk("forced4_addr", 64'(addr_rd), 64'd4);
      chk("forced4_data", 64'(data_rd), 64'h44);
      alu_valid = 1'b0;
      cyc();

      // re-issue to x9 in the same cycle its previous load retires
      lsu_issue = 1'b1; lsu_issue_rd = 5'd9;
      cyc();
      chk("busy9_set", 64'(busy[9]), 64'd1);
      lsu_issue = 1'b0;
      lsu_valid = 1'b1; lsu_rd = 5'd9; lsu_data = 32'h99;
      cyc();
      lsu_valid = 1'b0;
      lsu_issue = 1'b1; lsu_issue_rd = 5'd9;
      cyc();
      chk("ld9_addr", 64'(addr_rd), 64'd9);
      chk("busy9_setwins", 64'(busy[9]), 64'd1);
      lsu_issue = 1'b0;
      cyc();
      chk("busy9_hold", 64'(busy[9]), 64'd1);

      // streaming loads: push and pop together, pointers wrap
      lsu_valid = 1'b1; lsu_rd = 5'd11;
      for (int i = 0; i < 3; i++) begin
         lsu_data = 32'h1000 + 32'(i);
         cyc();
      end
      chk("stream_addr", 64'(addr_rd), 64'd11);
      chk("stream_data", 64'(data_rd), 64'h1001);
      lsu_valid = 1'b0;
      cyc(); cyc();

      // load to x0 consumed without a write
      lsu_valid = 1'b1; lsu_rd = 5'd0; lsu_data = 32'h77;
      cyc();
      lsu_valid = 1'b0;
      cyc();
      chk("ldx0_wr_en", 64'(wr_en), 64'd0);

      // reset with two buffered loads and busy[3] pending
      alu_valid = 1'b1; alu_rd = 5'd12; alu_data = 32'h12;
      lsu_issue = 1'b1; lsu_issue_rd = 5'd3;
      cyc();
      lsu_issue = 1'b0;
      lsu_valid = 1'b1; lsu_rd = 5'd3; lsu_data = 32'h3;
      cyc();
      lsu_rd = 5'd5; lsu_data = 32'h5;
      cyc();
      lsu_valid = 1'b0;
      chk("pre_rst_lsu_ready", 64'(lsu_ready), 64'd0);
      chk("pre_rst_busy3", 64'(busy[3]), 64'd1);
      reset_n = 1'b0; alu_valid = 1'b0;
      #2;
      chk("mid_rst_wr_en", 64'(wr_en), 64'd0);
      chk("mid_rst_busy", 64'(busy), 64'd0);
      chk("mid_rst_lsu_ready", 64'(lsu_ready), 64'd1);
      cyc();
      reset_n = 1'b1;
      repeat (3) begin
         cyc();
         chk("post_rst_wr_en", 64'(wr_en), 64'd0);
      end
      chk("post_rst_lsu_ready", 64'(lsu_ready), 64'd1);
      chk("post_rst_busy", 64'(busy), 64'd0);

      chk_on = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
